// File: rtl/bank_rsp_credit_return.sv
// ---------------------------------------------------------------------------
// bank_rsp_credit_return
//
// Return end of the per-channel read-credit protocol. Every memory channel
// owns CREDIT_NUM response slots (one per credit granted by the issue side),
// so channels push without backpressure. Buffered responses are round-robin
// arbitrated onto one output stream, and each response popped returns one
// credit to its channel through a one-cycle release pulse.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   ch_rsp_valid[c]          push strobe for channel c (no ready)
//   ch_rsp_data / ch_rsp_tag flattened per-channel payload, channel c at
//                            [c*W +: W]
//   out_valid / out_ready    arbitrated output handshake
//   out_data / out_tag       show-ahead head of the granted channel
//   out_ch_id                granted channel
//   channels_credit_release  one-cycle pulse per popped response
//   overflow_err             sticky per-channel "push dropped while full"
//   ch_occupancy             per-channel entry count, 4 bits each
// ---------------------------------------------------------------------------
module bank_rsp_credit_return #(
  parameter int CHANNEL_NUM = 3,
  parameter int CREDIT_NUM  = 8,
  parameter int DATA_WIDTH  = 64,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHANNEL_NUM-1:0]          ch_rsp_valid,
  input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] ch_rsp_data,
  input  logic [CHANNEL_NUM*TAG_WIDTH-1:0]  ch_rsp_tag,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [TAG_WIDTH-1:0]            out_tag,
  output logic [1:0]                      out_ch_id,
  output logic [CHANNEL_NUM-1:0]          channels_credit_release,
  output logic [CHANNEL_NUM-1:0]          overflow_err,
  output logic [CHANNEL_NUM*4-1:0]        ch_occupancy
);

  localparam int PTR_W   = (CREDIT_NUM > 1) ? $clog2(CREDIT_NUM) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_WIDTH + TAG_WIDTH;

  logic [CHANNEL_NUM-1:0]         not_empty;
  logic [CHANNEL_NUM-1:0]         pop;
  logic [CHANNEL_NUM*ENTRY_W-1:0] head_flat;

  logic [1:0] rr_ptr_reg;
  logic       lock_reg;
  logic [1:0] lock_ch_reg;
  logic [1:0] search_grant;
  logic [1:0] grant;
  logic       found;
  logic       handshake;
  int         idx;

  // -------------------------------------------------------------------------
  // Per-channel response buffers
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < CHANNEL_NUM; gi++) begin : g_ch
      logic [ENTRY_W-1:0] mem [CREDIT_NUM];
      logic [PTR_W-1:0]   wr_ptr_reg;
      logic [PTR_W-1:0]   rd_ptr_reg;
      logic [CNT_W-1:0]   count_reg;
      logic               overflow_reg;
      logic               full;
      logic               push_accept;

      assign full      = (count_reg == CNT_W'(CREDIT_NUM));
      assign not_empty[gi] = (count_reg != '0);
      // A pop in the same cycle frees the slot the push needs, so a push at
      // full is still accepted in that case.
      assign push_accept = ch_rsp_valid[gi] & (~full | pop[gi]);

      // Storage has no reset: contents are meaningless until counted.
      always_ff @(posedge clk) begin
        if (push_accept) begin
          mem[wr_ptr_reg] <= {ch_rsp_tag[gi*TAG_WIDTH +: TAG_WIDTH],
                              ch_rsp_data[gi*DATA_WIDTH +: DATA_WIDTH]};
        end
      end

      // Show-ahead head read.
      assign head_flat[gi*ENTRY_W +: ENTRY_W] = mem[rd_ptr_reg];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_ptr_reg   <= '0;
          rd_ptr_reg   <= '0;
          count_reg    <= '0;
          overflow_reg <= 1'b0;
        end else begin
          if (push_accept) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          end
          if (pop[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          end
          case ({push_accept, pop[gi]})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
          endcase
          if (ch_rsp_valid[gi] && full && !pop[gi]) begin
            overflow_reg <= 1'b1;
          end
        end
      end

      assign overflow_err[gi]          = overflow_reg;
      assign ch_occupancy[gi*4 +: 4]   = 4'(count_reg);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin search starting at rr_ptr
  // -------------------------------------------------------------------------
  always_comb begin
    search_grant = 2'd0;
    found        = 1'b0;
    idx          = 0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      idx = int'(rr_ptr_reg) + i;
      if (idx >= CHANNEL_NUM) begin
        idx = idx - CHANNEL_NUM;
      end
      if (!found && not_empty[idx]) begin
        found        = 1'b1;
        search_grant = 2'(idx);
      end
    end
  end

  // A stalled grant is held so the consumer sees a stable response even if
  // a higher-priority channel fills while it waits.
  assign grant     = lock_reg ? lock_ch_reg : search_grant;
  assign out_valid = |not_empty;
  assign out_ch_id = grant;
  assign handshake = out_valid & out_ready;

  always_comb begin
    pop      = '0;
    out_data = '0;
    out_tag  = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      if (grant == 2'(c)) begin
        pop[c]   = handshake;
        out_data = head_flat[c*ENTRY_W +: DATA_WIDTH];
        out_tag  = head_flat[c*ENTRY_W + DATA_WIDTH +: TAG_WIDTH];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Arbiter state and credit release
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg              <= 2'd0;
      lock_reg                <= 1'b0;
      lock_ch_reg             <= 2'd0;
      channels_credit_release <= '0;
    end else begin
      channels_credit_release <= pop;
      if (handshake) begin
        lock_reg   <= 1'b0;
        rr_ptr_reg <= (grant == 2'(CHANNEL_NUM - 1)) ? 2'd0 : grant + 2'd1;
      end else if (out_valid) begin
        lock_reg    <= 1'b1;
        lock_ch_reg <= grant;
      end
    end
  end

  // Only one channel can be popped per cycle, so at most one credit returns.
  release_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(channels_credit_release));

  // A held grant must always point at a channel with a head entry.
  lock_nonempty: assert property (@(posedge clk) disable iff (rst)
    lock_reg |-> out_valid);

endmodule

// File: tb/tb_bank_rsp_credit_return.sv
module tb_bank_rsp_credit_return;

  logic        clk;
  logic        rst;
  logic [2:0]  ch_rsp_valid;
  logic [191:0] ch_rsp_data;
  logic [23:0] ch_rsp_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_tag;
  logic [1:0]  out_ch_id;
  logic [2:0]  channels_credit_release;
  logic [2:0]  overflow_err;
  logic [11:0] ch_occupancy;

  int checks;
  int failures;

  bank_rsp_credit_return #(
    .CHANNEL_NUM(3), .CREDIT_NUM(8), .DATA_WIDTH(64), .TAG_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_rsp_valid(ch_rsp_valid), .ch_rsp_data(ch_rsp_data), .ch_rsp_tag(ch_rsp_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_ch_id(out_ch_id),
    .channels_credit_release(channels_credit_release),
    .overflow_err(overflow_err), .ch_occupancy(ch_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a push for channel ch; data is the tag replicated 8 times.
  task automatic set_push(input int ch, input logic [7:0] tag);
    ch_rsp_valid[ch] = 1'b1;
    ch_rsp_tag[ch*8 +: 8] = tag;
    ch_rsp_data[ch*64 +: 64] = {8{tag}};
  endtask

  task automatic clear_push();
    ch_rsp_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    ch_rsp_valid = '0;
    ch_rsp_data = '0;
    ch_rsp_tag = '0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (out_ch_id !== 2'd0) begin failures++; $display("FAIL reset_ch_id got=%0d exp=0", out_ch_id); end
    checks++; if (channels_credit_release !== 3'b000) begin failures++; $display("FAIL reset_release got=%b exp=000", channels_credit_release); end
    checks++; if (overflow_err !== 3'b000) begin failures++; $display("FAIL reset_overflow got=%b exp=000", overflow_err); end
    checks++; if (ch_occupancy !== 12'h000) begin failures++; $display("FAIL reset_occupancy got=%h exp=000", ch_occupancy); end
    rst = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    set_push(1, 8'h15);
    ch_rsp_data[64 +: 64] = 64'hA5;
    step();                // cycle 1
    clear_push();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
    checks++; if (out_ch_id !== 2'd1) begin failures++; $display("FAIL single_ch_id got=%0d exp=1", out_ch_id); end
    checks++; if (out_tag !== 8'h15) begin failures++; $display("FAIL single_tag got=%h exp=15", out_tag); end
    checks++; if (out_data !== 64'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", out_data); end
    checks++; if (ch_occupancy[7:4] !== 4'd1) begin failures++; $display("FAIL single_occ1 got=%0d exp=1", ch_occupancy[7:4]); end
    checks++; if (channels_credit_release !== 3'b000) begin failures++; $display("FAIL single_rel_c1 got=%b exp=000", channels_credit_release); end
    step();                // cycle 2
    checks++; if (channels_credit_release !== 3'b010) begin failures++; $display("FAIL single_rel_c2 got=%b exp=010", channels_credit_release); end
    checks++; if (ch_occupancy[7:4] !== 4'd0) begin failures++; $display("FAIL single_occ_drained got=%0d exp=0", ch_occupancy[7:4]); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_valid_c2 got=%0b exp=0", out_valid); end
    step();                // cycle 3
    checks++; if (channels_credit_release !== 3'b000) begin failures++; $display("FAIL single_rel_c3 got=%b exp=000", channels_credit_release); end
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [3];
    logic [2:0] exp_rel [3];
    exp_id = '{2'd0, 2'd1, 2'd2};
    exp_rel = '{3'b000, 3'b001, 3'b010};
    rst = 1'b1; step(); rst = 1'b0;  // rr_ptr back to 0
    out_ready = 1'b1;
    set_push(0, 8'h20); set_push(1, 8'h21); set_push(2, 8'h22);
    step();
    clear_push();
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b1 || out_ch_id !== exp_id[k]) begin failures++; $display("FAIL rr_grant%0d got=%0b/%0d exp=1/%0d", k, out_valid, out_ch_id, exp_id[k]); end
      checks++; if (out_tag !== 8'h20 + 8'(k)) begin failures++; $display("FAIL rr_tag%0d got=%h exp=%h", k, out_tag, 8'h20 + 8'(k)); end
      checks++; if (channels_credit_release !== exp_rel[k]) begin failures++; $display("FAIL rr_rel%0d got=%b exp=%b", k, channels_credit_release, exp_rel[k]); end
      step();
    end
    checks++; if (channels_credit_release !== 3'b100 || out_valid !== 1'b0) begin failures++; $display("FAIL rr_last got=rel %b valid %0b exp=rel 100 valid 0", channels_credit_release, out_valid); end
    // rr_ptr must be 0: with ch0 and ch2 pending, ch0 wins.
    set_push(0, 8'h23); set_push(2, 8'h24);
    step();
    clear_push();
    checks++; if (out_ch_id !== 2'd0 || out_tag !== 8'h23) begin failures++; $display("FAIL rr_ptr_wrap got=%0d/%h exp=0/23", out_ch_id, out_tag); end
    step();
    checks++; if (out_ch_id !== 2'd2 || out_tag !== 8'h24) begin failures++; $display("FAIL rr_second got=%0d/%h exp=2/24", out_ch_id, out_tag); end
    step();
    checks++; if (channels_credit_release !== 3'b100 || out_valid !== 1'b0) begin failures++; $display("FAIL rr_second_rel got=%b/%0b exp=100/0", channels_credit_release, out_valid); end
    step();
    $display("test_round_robin done");
  endtask

  task automatic test_lock();
    out_ready = 1'b0;
    set_push(2, 8'h32);
    step();                // ch2 granted, stalled
    clear_push();
    set_push(0, 8'h30);
    checks++; if (out_ch_id !== 2'd2 || out_tag !== 8'h32) begin failures++; $display("FAIL lock_first got=%0d/%h exp=2/32", out_ch_id, out_tag); end
    step();                // ch0 now non-empty and would win from rr_ptr 0
    clear_push();
    for (int k = 0; k < 2; k++) begin
      checks++; if (out_ch_id !== 2'd2 || out_tag !== 8'h32 || out_data !== {8{8'h32}}) begin failures++; $display("FAIL lock_hold%0d got=%0d/%h exp=2/32", k, out_ch_id, out_tag); end
      if (k == 1) out_ready = 1'b1;
      step();
    end
    checks++; if (out_ch_id !== 2'd0 || out_tag !== 8'h30 || channels_credit_release !== 3'b100) begin failures++; $display("FAIL lock_next got=%0d/%h/%b exp=0/30/100", out_ch_id, out_tag, channels_credit_release); end
    step();
    checks++; if (channels_credit_release !== 3'b001 || out_valid !== 1'b0) begin failures++; $display("FAIL lock_done got=%b/%0b exp=001/0", channels_credit_release, out_valid); end
    step();
    $display("test_lock done");
  endtask

  task automatic test_overflow();
    int rel_count;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_push(0, 8'h40 + 8'(i));
      step();
    end
    clear_push();
    checks++; if (ch_occupancy[3:0] !== 4'd8 || overflow_err !== 3'b000) begin failures++; $display("FAIL ovf_fill got=%0d/%b exp=8/000", ch_occupancy[3:0], overflow_err); end
    set_push(0, 8'hFF);
    step();
    clear_push();
    checks++; if (ch_occupancy[3:0] !== 4'd8 || overflow_err !== 3'b001) begin failures++; $display("FAIL ovf_drop got=%0d/%b exp=8/001", ch_occupancy[3:0], overflow_err); end
    out_ready = 1'b1;
    rel_count = 0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_valid !== 1'b1 || out_ch_id !== 2'd0 || out_tag !== 8'h40 + 8'(i)) begin failures++; $display("FAIL ovf_drain%0d got=%0b/%0d/%h exp=1/0/%h", i, out_valid, out_ch_id, out_tag, 8'h40 + 8'(i)); end
      step();
      if (channels_credit_release == 3'b001) rel_count++;
    end
    step();
    if (channels_credit_release != 3'b000) rel_count++;
    checks++; if (rel_count != 8) begin failures++; $display("FAIL ovf_releases got=%0d exp=8", rel_count); end
    checks++; if (out_valid !== 1'b0 || ch_occupancy[3:0] !== 4'd0 || overflow_err !== 3'b001) begin failures++; $display("FAIL ovf_empty got=%0b/%0d/%b exp=0/0/001", out_valid, ch_occupancy[3:0], overflow_err); end
    $display("test_overflow done");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_push(1, 8'h51 + 8'(i));
      step();
    end
    clear_push();
    checks++; if (ch_occupancy[7:4] !== 4'd3) begin failures++; $display("FAIL rmid_occ got=%0d exp=3", ch_occupancy[7:4]); end
    rst = 1'b1;
    out_ready = 1'b1;
    #1;                    // asynchronous: no clock edge in between
    checks++; if (out_valid !== 1'b0 || ch_occupancy !== 12'h000 || overflow_err !== 3'b000) begin failures++; $display("FAIL rmid_async got=%0b/%h/%b exp=0/000/000", out_valid, ch_occupancy, overflow_err); end
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (channels_credit_release !== 3'b000 || out_valid !== 1'b0) begin failures++; $display("FAIL rmid_quiet%0d got=%b/%0b exp=000/0", k, channels_credit_release, out_valid); end
    end
    set_push(2, 8'h66);
    step();
    clear_push();
    checks++; if (out_valid !== 1'b1 || out_ch_id !== 2'd2 || out_tag !== 8'h66) begin failures++; $display("FAIL rmid_after got=%0b/%0d/%h exp=1/2/66", out_valid, out_ch_id, out_tag); end
    step();
    checks++; if (channels_credit_release !== 3'b100) begin failures++; $display("FAIL rmid_rel got=%b exp=100", channels_credit_release); end
    step();
    $display("test_reset_mid done");
  endtask

  task automatic test_full_push_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_push(0, 8'h70 + 8'(i));
      step();
    end
    clear_push();
    checks++; if (ch_occupancy[3:0] !== 4'd8 || out_tag !== 8'h70) begin failures++; $display("FAIL fpp_full got=%0d/%h exp=8/70", ch_occupancy[3:0], out_tag); end
    out_ready = 1'b1;
    set_push(0, 8'h78);
    step();
    clear_push();
    out_ready = 1'b0;
    checks++; if (ch_occupancy[3:0] !== 4'd8 || overflow_err !== 3'b000) begin failures++; $display("FAIL fpp_accept got=%0d/%b exp=8/000", ch_occupancy[3:0], overflow_err); end
    checks++; if (channels_credit_release !== 3'b001 || out_tag !== 8'h71) begin failures++; $display("FAIL fpp_rel got=%b/%h exp=001/71", channels_credit_release, out_tag); end
    step();
    checks++; if (channels_credit_release !== 3'b000 || ch_occupancy[3:0] !== 4'd8) begin failures++; $display("FAIL fpp_hold got=%b/%0d exp=000/8", channels_credit_release, ch_occupancy[3:0]); end
    out_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      checks++; if (out_valid !== 1'b1 || out_tag !== 8'h70 + 8'(i)) begin failures++; $display("FAIL fpp_drain%0d got=%0b/%h exp=1/%h", i, out_valid, out_tag, 8'h70 + 8'(i)); end
      step();
    end
    checks++; if (out_valid !== 1'b0 || ch_occupancy[3:0] !== 4'd0) begin failures++; $display("FAIL fpp_empty got=%0b/%0d exp=0/0", out_valid, ch_occupancy[3:0]); end
    $display("test_full_push_pop done");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_overflow();
    test_reset_mid();
    test_full_push_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
